issue_credit_ctrl: RTL and testbench

//  Issue-stage flow controller. It tracks free entries in the ROB, the RS and the LSB, and grants

---
 rtl/issue_credit_ctrl_pkg.sv | 18 +
 rtl/issue_credit_ctrl_counter.sv | 42 ++++
 rtl/issue_credit_ctrl.sv | 108 ++++++++++
 tb/tb_issue_credit_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_credit_ctrl_pkg.sv
// Shared constants and FSM encoding for the issue-stage credit controller.
package issue_credit_ctrl_pkg;

  localparam int ROB_IDX_W     = 6;
  localparam int ROB_DEPTH_DEF = 64;
  localparam int RS_DEPTH_DEF  = 16;
  localparam int LSB_DEPTH_DEF = 16;
  localparam int ROB_CNT_W     = 7;
  localparam int RS_CNT_W      = 5;
  localparam int LSB_CNT_W     = 5;
  localparam int HOLD_W        = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } issue_state_e;

endpackage

// File: rtl/issue_credit_ctrl_counter.sv
// Occupancy counter for one issue target: +1 on issue, -1 on release, cleared by flush.
module credit_counter #(
  parameter int DEPTH = 16,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         uflow
);

  logic         dec_ok;
  logic [W-1:0] cnt_nxt;

  // A release against an empty counter is dropped and reported instead.
  assign dec_ok = dec && (cnt != '0);
  assign uflow  = en && !clr && dec && (cnt == '0);
  assign full   = (cnt == W'(DEPTH));

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (inc && !dec_ok)
      cnt_nxt = cnt + W'(1);
    else if (!inc && dec_ok)
      cnt_nxt = cnt - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (en)
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/issue_credit_ctrl.sv
// Issue-stage flow control: grants IF's instruction when ROB and RS/LSB have room,
// owns the ROB tail, and forces a short stall window after a flush.
module issue_credit_ctrl
  import issue_credit_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH  = ROB_DEPTH_DEF,
  parameter int RS_DEPTH   = RS_DEPTH_DEF,
  parameter int LSB_DEPTH  = LSB_DEPTH_DEF,
  parameter int FLUSH_HOLD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 if_valid,
  input  logic                 if_is_mem,
  output logic                 issue_grant,
  output logic [ROB_IDX_W-1:0] issue_rob_idx,
  input  logic                 rob_commit,
  input  logic                 rs_free,
  input  logic                 lsb_free,
  input  logic                 flush,
  output logic [ROB_CNT_W-1:0] rob_cnt,
  output logic [RS_CNT_W-1:0]  rs_cnt,
  output logic [LSB_CNT_W-1:0] lsb_cnt,
  output logic                 stall,
  output logic                 underflow_err
);

  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(FLUSH_HOLD - 1);
  localparam logic [ROB_IDX_W-1:0] TAIL_LAST = ROB_IDX_W'(ROB_DEPTH - 1);

  issue_state_e         state, state_nxt;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic [ROB_IDX_W-1:0] tail;
  logic                 clr;
  logic                 rob_full, rs_full, lsb_full;
  logic                 rob_uf, rs_uf, lsb_uf;
  logic                 credit_ok;

  assign clr       = rdy && flush;
  assign credit_ok = !rob_full && (if_is_mem ? !lsb_full : !rs_full);

  // Gated by rst_n so nothing is granted while reset is held.
  assign issue_grant   = rst_n && rdy && (state == ST_RUN) && !flush && if_valid && credit_ok;
  assign stall         = rst_n && if_valid && !issue_grant;
  assign issue_rob_idx = tail;

  credit_counter #(.DEPTH(ROB_DEPTH), .W(ROB_CNT_W)) u_rob_cnt (
    .clk(clk), .rst_n(rst_n), .en(rdy), .inc(issue_grant), .dec(rob_commit),
    .clr(clr), .cnt(rob_cnt), .full(rob_full), .uflow(rob_uf)
  );

  credit_counter #(.DEPTH(RS_DEPTH), .W(RS_CNT_W)) u_rs_cnt (
    .clk(clk), .rst_n(rst_n), .en(rdy), .inc(issue_grant && !if_is_mem), .dec(rs_free),
    .clr(clr), .cnt(rs_cnt), .full(rs_full), .uflow(rs_uf)
  );

  credit_counter #(.DEPTH(LSB_DEPTH), .W(LSB_CNT_W)) u_lsb_cnt (
    .clk(clk), .rst_n(rst_n), .en(rdy), .inc(issue_grant && if_is_mem), .dec(lsb_free),
    .clr(clr), .cnt(lsb_cnt), .full(lsb_full), .uflow(lsb_uf)
  );

  // A flush in either state (re)loads the hold window.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (rdy) begin
      if (flush) begin
        state_nxt = ST_HOLD;
        hold_nxt  = HOLD_LAST;
      end else if (state == ST_HOLD) begin
        if (hold_cnt == '0)
          state_nxt = ST_RUN;
        else
          hold_nxt = hold_cnt - HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tail <= '0;
    else if (rdy) begin
      if (flush)
        tail <= '0;
      else if (issue_grant)
        tail <= (tail == TAIL_LAST) ? '0 : tail + ROB_IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      underflow_err <= 1'b0;
    else if (rdy && (rob_uf || rs_uf || lsb_uf))
      underflow_err <= 1'b1;
  end

endmodule

// File: tb/tb_issue_credit_ctrl.sv
// Directed bench for issue_credit_ctrl: credits, ROB wrap, flush hold, underflow, rdy freeze.
module tb_issue_credit_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy, if_valid, if_is_mem, rob_commit, rs_free, lsb_free, flush;
  logic       issue_grant, stall, underflow_err;
  logic [5:0] issue_rob_idx;
  logic [6:0] rob_cnt;
  logic [4:0] rs_cnt, lsb_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int rs_m, lsb_m;

  issue_credit_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .if_valid(if_valid), .if_is_mem(if_is_mem),
    .issue_grant(issue_grant), .issue_rob_idx(issue_rob_idx), .rob_commit(rob_commit),
    .rs_free(rs_free), .lsb_free(lsb_free), .flush(flush), .rob_cnt(rob_cnt),
    .rs_cnt(rs_cnt), .lsb_cnt(lsb_cnt), .stall(stall), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    rdy = 1'b1; if_valid = 1'b0; if_is_mem = 1'b0;
    rob_commit = 1'b0; rs_free = 1'b0; lsb_free = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with an instruction presented
    rst_n = 1'b0;
    clr_in();
    if_valid = 1'b1;
    #2;
    chk("rst_grant", issue_grant, 0);
    chk("rst_stall", stall, 0);
    tick(); tick();
    chk("rst_rob", rob_cnt, 0);
    chk("rst_rs", rs_cnt, 0);
    chk("rst_lsb", lsb_cnt, 0);
    chk("rst_idx", issue_rob_idx, 0);
    chk("rst_uflow", underflow_err, 0);
    rst_n = 1'b1;
    #1;
    chk("run_grant", issue_grant, 1);

    // fill the RS
    for (int i = 0; i < 16; i++) begin
      if_valid = 1'b1; if_is_mem = 1'b0;
      #1;
      chk("rs_fill_grant", issue_grant, 1);
      chk("rs_fill_idx", issue_rob_idx, 32'(i));
      tick();
    end
    chk("rs_full_cnt", rs_cnt, 16);
    chk("rs_full_rob", rob_cnt, 16);
    chk("rs_full_grant", issue_grant, 0);
    chk("rs_full_stall", stall, 1);
    if_is_mem = 1'b1;
    #1;
    chk("mem_grant", issue_grant, 1);
    tick();
    chk("mem_lsb", lsb_cnt, 1);
    chk("mem_rob", rob_cnt, 17);

    // drain RS and LSB
    clr_in();
    rs_free = 1'b1; lsb_free = 1'b1;
    tick();
    lsb_free = 1'b0;
    repeat (15) tick();
    rs_free = 1'b0;
    chk("drain_rs", rs_cnt, 0);
    chk("drain_lsb", lsb_cnt, 0);
    chk("drain_rob", rob_cnt, 17);

    // fill ROB to 64 with alternating types
    rs_m = 0; lsb_m = 0;
    for (int k = 0; k < 47; k++) begin
      if_valid = 1'b1;
      if_is_mem = k[0];
      rs_free = (rs_m != 0);
      lsb_free = (lsb_m != 0);
      #1;
      chk("rob_fill_grant", issue_grant, 1);
      chk("rob_fill_idx", issue_rob_idx, 32'(17 + k));
      tick();
      if (rs_free) rs_m--;
      if (lsb_free) lsb_m--;
      if (if_is_mem) lsb_m++; else rs_m++;
    end
    chk("rob_full_cnt", rob_cnt, 64);
    chk("rob_full_rs", rs_cnt, 32'(rs_m));
    chk("rob_full_lsb", lsb_cnt, 32'(lsb_m));
    chk("rob_full_idx", issue_rob_idx, 0);
    clr_in();
    if_valid = 1'b1; rob_commit = 1'b1;
    #1;
    chk("rob_full_grant", issue_grant, 0);
    chk("rob_full_stall", stall, 1);
    tick();
    rob_commit = 1'b0;
    #1;
    chk("commit_rob", rob_cnt, 63);
    chk("wrap_grant", issue_grant, 1);
    chk("wrap_idx", issue_rob_idx, 0);
    tick();
    chk("wrap_rob", rob_cnt, 64);
    chk("wrap_idx_next", issue_rob_idx, 1);

    // commit down to 20, then flush
    clr_in();
    rob_commit = 1'b1;
    repeat (44) tick();
    rob_commit = 1'b0;
    chk("pre_flush_rob", rob_cnt, 20);
    flush = 1'b1; rob_commit = 1'b1; if_valid = 1'b1;
    #1;
    chk("flush_grant", issue_grant, 0);
    tick();
    flush = 1'b0; rob_commit = 1'b0;
    chk("flush_rob", rob_cnt, 0);
    chk("flush_rs", rs_cnt, 0);
    chk("flush_lsb", lsb_cnt, 0);
    chk("flush_idx", issue_rob_idx, 0);
    chk("flush_uflow", underflow_err, 0);
    chk("hold1_grant", issue_grant, 0);
    tick();
    chk("hold2_grant", issue_grant, 0);
    tick();
    if_is_mem = 1'b1;
    #1;
    chk("post_hold_grant", issue_grant, 1);
    chk("post_hold_idx", issue_rob_idx, 0);
    tick();
    chk("post_hold_lsb", lsb_cnt, 1);
    chk("post_hold_rob", rob_cnt, 1);
    chk("post_hold_idx1", issue_rob_idx, 1);

    // underflow on RS, sticky through flush
    clr_in();
    rs_free = 1'b1;
    tick();
    rs_free = 1'b0;
    chk("uf_rs", rs_cnt, 0);
    chk("uf_err", underflow_err, 1);
    chk("uf_lsb", lsb_cnt, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("uf_after_flush", underflow_err, 1);
    chk("uf_flush_rob", rob_cnt, 0);
    tick(); tick();
    chk("uf_after_hold", underflow_err, 1);

    // rdy low freezes everything
    if_valid = 1'b1;
    #1;
    chk("pre_rdy_grant", issue_grant, 1);
    tick();
    if_valid = 1'b0;
    chk("pre_rdy_rob", rob_cnt, 1);
    chk("pre_rdy_rs", rs_cnt, 1);
    rdy = 1'b0; if_valid = 1'b1; rob_commit = 1'b1;
    #1;
    chk("rdy0_grant", issue_grant, 0);
    chk("rdy0_stall", stall, 1);
    tick();
    if_valid = 1'b0; flush = 1'b1; rs_free = 1'b1;
    #1;
    chk("rdy0_stall_idle", stall, 0);
    tick();
    if_valid = 1'b1; lsb_free = 1'b1; rob_commit = 1'b0;
    tick();
    clr_in();
    chk("rdy0_rob", rob_cnt, 1);
    chk("rdy0_rs", rs_cnt, 1);
    chk("rdy0_lsb", lsb_cnt, 0);
    chk("rdy0_idx", issue_rob_idx, 1);
    if_valid = 1'b1;
    #1;
    chk("rdy0_state_run", issue_grant, 1);
    tick();
    chk("rdy1_rob", rob_cnt, 2);
    chk("rdy1_idx", issue_rob_idx, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
